hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the five-stage MIPS pipeline. It generates the ID-stage branch-compare forwarding selects (forwardAD/forwardBD) and the EX-stage operand forwarding selects. It detects load-use and branch-operand hazards, and sequences multi-cycle stalls for the iterative multiply/divide unit and for a slow data memory. It sits beside the datapath and drives the stall and flush enables of the F/D, D/E, E/M and M/W pipeline registers.

## Interface
- MD_CYCLES, 32: iteration count of the mul/div unit (≥2).
- MEM_TIMEOUT, 255: maximum MEM_WAIT cycles before memTimeout is flagged (≥1).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-low reset.
- rsD, rtD  in  5 each  source registers of the instruction in ID.
- branchD  in  1  ID instruction is a beq/bne (compares rs, rt in ID).
- jrD  in  1  ID instruction is jr/jalr (reads rs in ID).
- rsE, rtE  in  5 each  source registers of the instruction in EX.
- writeRegAddrE, writeRegAddrM, writeRegAddrW  in  5 each  destination registers.
- Regfile_weE, Regfile_weM, Regfile_weW  in  1 each  register write enables per stage.
- memToRegE, memToRegM  in  1 each  stage holds a load.
- mdStartE  in  1  EX holds a mult/div instruction.
- memReqM  in  1  MEM stage performs a data-memory access.
- dmemReady  in  1  data memory completes the access this cycle.
- forwardAD, forwardBD  out  1 each  ID compare operand takes aluOutM.
- forwardAE, forwardBE  out  2 each  EX operand select: 00 regfile, 01 wbOut, 10 aluOutM.
- stallF, stallD, stallE, stallM  out  1 each  hold the PC / pipeline register.
- flushE, flushM, flushW  out  1 each  insert a bubble into the register.
- mdGo  out  1  one-cycle start pulse to the mul/div unit.
- mdBusy  out  1  FSM in MD_BUSY.
- mdDone  out  1  last cycle of a mul/div operation.
- memTimeout  out  1  sticky; a memory wait exceeded MEM_TIMEOUT.

## Operation
- Register 0 never matches in any comparison.
- Forwarding:
  - forwardAE = 10 if Regfile_weM and writeRegAddrM==rsE; else 01 if Regfile_weW and writeRegAddrW==rsE; else 00. M-stage priority over W.
  - forwardBE: same rule using rtE.
  - forwardAD = Regfile_weM and writeRegAddrM==rsD. forwardBD: same using rtD.
- lwStall = memToRegE and writeRegAddrE ∈ {rsD, rtD}.
- brStall = (branchD or jrD) and the ID source matches either:
  - writeRegAddrE with Regfile_weE, or
  - writeRegAddrM with memToRegM.
  - jrD checks rsD only.
- FSM states IDLE, MD_BUSY, MEM_WAIT. memWait = memReqM and !dmemReady.
- IDLE transitions:
  - memWait → MEM_WAIT, waitCnt←1. memWait has priority over mdStartE.
  - else mdStartE → MD_BUSY, mdGo=1, cnt←MD_CYCLES-1.
- MD_BUSY:
  - cnt decrements each cycle.
  - When cnt==0: mdDone=1, no stall, → IDLE.
  - memReqM is ignored (MEM holds bubbles).
- MEM_WAIT:
  - dmemReady → IDLE.
  - Otherwise waitCnt increments, saturating. waitCnt==MEM_TIMEOUT sets memTimeout, which stays set until reset. The wait continues.
- Stall/flush rules:
  - Hazard stall (IDLE, no memWait, no mdStartE): stallF=stallD=lwStall|brStall, flushE=lwStall|brStall.
  - Mul/div stall (IDLE with mdStartE and no memWait, or MD_BUSY with cnt≠0): stallF=stallD=stallE=1, flushM=1, flushE=0. forwardA/B* remain active.
  - Memory stall (IDLE with memWait, or MEM_WAIT with !dmemReady): stallF=stallD=stallE=stallM=1, flushW=1, flushE=flushM=0.
  - All other outputs 0.
- A hazard stall never coincides with an FSM stall. During FSM stalls the hazard-derived flushE is suppressed.

## Timing
- All hazard, forwarding and stall outputs are combinational from the inputs and the registered state. State, cnt, waitCnt and memTimeout are updated on the rising clk edge.
- Reset (rst==0 at the edge):
  - state←IDLE, cnt←0, waitCnt←0, memTimeout←0.
  - While rst==0, every output is forced to 0.
  - Reset mid-MD_BUSY or mid-MEM_WAIT abandons the operation; mdDone is not pulsed.
- Mul/div latency:
  - mdGo asserts in the mdStartE cycle (cycle 0). mdDone asserts in cycle MD_CYCLES.
  - EX is stalled for exactly MD_CYCLES cycles (0..MD_CYCLES-1) and advances at the end of cycle MD_CYCLES.
- Back-to-back mul/div: a new mdStartE is accepted in the IDLE cycle immediately after mdDone.
- Memory: the stall lasts while !dmemReady. In the dmemReady cycle no stall is asserted and state returns to IDLE.
- cnt width: $clog2(MD_CYCLES). waitCnt width: $clog2(MEM_TIMEOUT+1).

## Test plan
- Forwarding: weM=1, writeRegAddrM=5, weW=1, writeRegAddrW=5, rsE=5 → forwardAE=10. With writeRegAddrM=0 → forwardAE=01. With rsE=0 → 00.
- Load-use: memToRegE=1, writeRegAddrE=8, rtD=8 → stallF=stallD=flushE=1 for one cycle. With writeRegAddrE=0 → no stall.
- Branch: branchD=1, rsD=3, Regfile_weE=1, writeRegAddrE=3 → one stall cycle. Next cycle, with the instruction now in M, forwardAD=1 and no stall.
- Mul/div, MD_CYCLES=4: mdStartE high in cycle 0 → mdGo in cycle 0, stallE=1 in cycles 0-3, mdDone=1 in cycle 4, mdBusy in cycles 1-4.
- Memory, MEM_TIMEOUT=3: memReqM=1, dmemReady low for 5 cycles → stallM high for 5 cycles, memTimeout set by cycle 3 and held. memReqM simultaneous with mdStartE → MEM_WAIT first, then MD_BUSY.
- Reset: rst low in cycle 2 of MD_BUSY → next cycle state IDLE, all outputs 0, no mdDone.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding selects, load-use / branch hazard detection and
// stall sequencing for the iterative mul/div unit and slow data memory.
module hazard_ctrl #(
    parameter int MD_CYCLES   = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic       branchD,
    input  logic       jrD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] writeRegAddrE,
    input  logic [4:0] writeRegAddrM,
    input  logic [4:0] writeRegAddrW,
    input  logic       Regfile_weE,
    input  logic       Regfile_weM,
    input  logic       Regfile_weW,
    input  logic       memToRegE,
    input  logic       memToRegM,
    input  logic       mdStartE,
    input  logic       memReqM,
    input  logic       dmemReady,
    output logic       forwardAD,
    output logic       forwardBD,
    output logic [1:0] forwardAE,
    output logic [1:0] forwardBE,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       stallM,
    output logic       flushE,
    output logic       flushM,
    output logic       flushW,
    output logic       mdGo,
    output logic       mdBusy,
    output logic       mdDone,
    output logic       memTimeout
);

    localparam int CW = $clog2(MD_CYCLES);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(MD_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        MD_BUSY,
        MEM_WAIT
    } state_t;

    state_t        r_state;
    state_t        w_state_n;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_n;
    logic [WW-1:0] r_waitCnt;
    logic [WW-1:0] w_waitCnt_n;
    logic          r_memTimeout;

    logic [1:0] w_fwdAE;
    logic [1:0] w_fwdBE;
    logic       w_fwdAD;
    logic       w_fwdBD;
    logic       w_lwStall;
    logic       w_rsBr;
    logic       w_rtBr;
    logic       w_brStall;
    logic       w_hazard;
    logic       w_memWait;
    logic       w_hzStall;
    logic       w_mdStall;
    logic       w_memStall;
    logic       w_go;
    logic       w_busy;
    logic       w_done;
    logic       w_toHit;

    // Register 0 is hardwired, so it never creates a dependency.
    function automatic logic hit(input logic [4:0] a, input logic [4:0] b);
        return (b != 5'd0) && (a == b);
    endfunction

    always_comb begin
        w_fwdAE = 2'b00;
        if (Regfile_weM && hit(writeRegAddrM, rsE)) begin
            w_fwdAE = 2'b10;
        end else if (Regfile_weW && hit(writeRegAddrW, rsE)) begin
            w_fwdAE = 2'b01;
        end
    end

    always_comb begin
        w_fwdBE = 2'b00;
        if (Regfile_weM && hit(writeRegAddrM, rtE)) begin
            w_fwdBE = 2'b10;
        end else if (Regfile_weW && hit(writeRegAddrW, rtE)) begin
            w_fwdBE = 2'b01;
        end
    end

    assign w_fwdAD = Regfile_weM && hit(writeRegAddrM, rsD);
    assign w_fwdBD = Regfile_weM && hit(writeRegAddrM, rtD);

    assign w_lwStall = memToRegE &&
        (hit(writeRegAddrE, rsD) || hit(writeRegAddrE, rtD));

    // A load in M cannot be forwarded to the ID comparator in time.
    assign w_rsBr = (Regfile_weE && hit(writeRegAddrE, rsD)) ||
                    (memToRegM && hit(writeRegAddrM, rsD));
    assign w_rtBr = (Regfile_weE && hit(writeRegAddrE, rtD)) ||
                    (memToRegM && hit(writeRegAddrM, rtD));

    assign w_brStall = (branchD && (w_rsBr || w_rtBr)) || (jrD && w_rsBr);
    assign w_hazard  = w_lwStall || w_brStall;
    assign w_memWait = memReqM && !dmemReady;

    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_waitCnt_n = r_waitCnt;
        w_hzStall   = 1'b0;
        w_mdStall   = 1'b0;
        w_memStall  = 1'b0;
        w_go        = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_toHit     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_memWait) begin
                    w_state_n   = MEM_WAIT;
                    w_waitCnt_n = WW'(1);
                    w_memStall  = 1'b1;
                end else if (mdStartE) begin
                    w_state_n = MD_BUSY;
                    w_cnt_n   = CNT_INIT;
                    w_go      = 1'b1;
                    w_mdStall = 1'b1;
                end else begin
                    w_hzStall = w_hazard;
                end
            end
            MD_BUSY: begin
                w_busy = 1'b1;
                if (r_cnt == '0) begin
                    w_done    = 1'b1;
                    w_state_n = IDLE;
                end else begin
                    w_cnt_n   = r_cnt - CW'(1);
                    w_mdStall = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (dmemReady) begin
                    w_state_n = IDLE;
                end else begin
                    w_memStall = 1'b1;
                    w_toHit    = (r_waitCnt == WAIT_MAX);
                    if (r_waitCnt != WAIT_MAX) begin
                        w_waitCnt_n = r_waitCnt + WW'(1);
                    end
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_waitCnt    <= '0;
            r_memTimeout <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_cnt        <= w_cnt_n;
            r_waitCnt    <= w_waitCnt_n;
            r_memTimeout <= r_memTimeout | w_toHit;
        end
    end

    // Every output is held low while reset is asserted.
    assign forwardAD  = rst & w_fwdAD;
    assign forwardBD  = rst & w_fwdBD;
    assign forwardAE  = rst ? w_fwdAE : 2'b00;
    assign forwardBE  = rst ? w_fwdBE : 2'b00;
    assign stallF     = rst & (w_hzStall | w_mdStall | w_memStall);
    assign stallD     = rst & (w_hzStall | w_mdStall | w_memStall);
    assign stallE     = rst & (w_mdStall | w_memStall);
    assign stallM     = rst & w_memStall;
    assign flushE     = rst & w_hzStall;
    assign flushM     = rst & w_mdStall;
    assign flushW     = rst & w_memStall;
    assign mdGo       = rst & w_go;
    assign mdBusy     = rst & w_busy;
    assign mdDone     = rst & w_done;
    assign memTimeout = rst & (r_memTimeout | w_toHit);

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table vectors, hand sequences and a randomized run
// against a cycle-level behavioural model of hazard_ctrl.
module tb_hazard_ctrl;

    localparam int MDC = 4;
    localparam int MTO = 3;

    typedef struct packed {
        logic [4:0] rsD, rtD;
        logic       branchD, jrD;
        logic [4:0] rsE, rtE, waE, waM, waW;
        logic       weE, weM, weW, m2rE, m2rM;
        logic       mdStartE, memReqM, dmemReady;
    } in_t;

    typedef struct packed {
        logic       fAD, fBD;
        logic [1:0] fAE, fBE;
        logic       sF, sD, sE, sM;
        logic       flE, flM, flW;
        logic       go, busy, done, to;
    } out_t;

    typedef struct {
        string name;
        in_t   in;
        out_t  exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rsD, rtD, rsE, rtE;
    logic [4:0] writeRegAddrE, writeRegAddrM, writeRegAddrW;
    logic       branchD, jrD;
    logic       Regfile_weE, Regfile_weM, Regfile_weW;
    logic       memToRegE, memToRegM, mdStartE, memReqM, dmemReady;
    logic       forwardAD, forwardBD;
    logic [1:0] forwardAE, forwardBE;
    logic       stallF, stallD, stallE, stallM;
    logic       flushE, flushM, flushW;
    logic       mdGo, mdBusy, mdDone, memTimeout;

    int n_cmp = 0;
    int n_err = 0;

    int   m_phase  = 0;
    int   m_age    = 0;
    int   m_waited = 0;
    logic m_to     = 1'b0;

    vec_t tbl[$];

    hazard_ctrl #(.MD_CYCLES(MDC), .MEM_TIMEOUT(MTO)) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD),
        .branchD(branchD), .jrD(jrD),
        .rsE(rsE), .rtE(rtE),
        .writeRegAddrE(writeRegAddrE),
        .writeRegAddrM(writeRegAddrM),
        .writeRegAddrW(writeRegAddrW),
        .Regfile_weE(Regfile_weE),
        .Regfile_weM(Regfile_weM),
        .Regfile_weW(Regfile_weW),
        .memToRegE(memToRegE), .memToRegM(memToRegM),
        .mdStartE(mdStartE), .memReqM(memReqM),
        .dmemReady(dmemReady),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .stallF(stallF), .stallD(stallD),
        .stallE(stallE), .stallM(stallM),
        .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .mdGo(mdGo), .mdBusy(mdBusy), .mdDone(mdDone),
        .memTimeout(memTimeout)
    );

    always #5 clk = ~clk;

    function automatic in_t base();
        in_t v;
        v = '0;
        v.dmemReady = 1'b1;
        return v;
    endfunction

    function automatic out_t got();
        out_t o;
        o = {forwardAD, forwardBD, forwardAE, forwardBE,
             stallF, stallD, stallE, stallM,
             flushE, flushM, flushW,
             mdGo, mdBusy, mdDone, memTimeout};
        return o;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic dep(input logic [4:0] a, input logic [4:0] s);
        return s != 5'd0 && a == s;
    endfunction

    function automatic logic [1:0] fsel(input in_t v, input logic [4:0] s);
        if (v.weM && dep(v.waM, s)) return 2'b10;
        if (v.weW && dep(v.waW, s)) return 2'b01;
        return 2'b00;
    endfunction

    // Phase 0 idle, 1 mul/div (m_age = cycle index since go), 2 mem wait.
    task automatic model_step(input in_t v, input logic r, output out_t e);
        logic lw, brs, brt, br;
        e = '0;
        if (!r) begin
            m_phase = 0; m_age = 0; m_waited = 0; m_to = 1'b0;
            return;
        end
        e.fAE = fsel(v, v.rsE);
        e.fBE = fsel(v, v.rtE);
        e.fAD = v.weM && dep(v.waM, v.rsD);
        e.fBD = v.weM && dep(v.waM, v.rtD);
        lw  = v.m2rE && (dep(v.waE, v.rsD) || dep(v.waE, v.rtD));
        brs = (v.weE && dep(v.waE, v.rsD)) || (v.m2rM && dep(v.waM, v.rsD));
        brt = (v.weE && dep(v.waE, v.rtD)) || (v.m2rM && dep(v.waM, v.rtD));
        br  = (v.branchD && (brs || brt)) || (v.jrD && brs);
        if (m_phase == 0) begin
            if (v.memReqM && !v.dmemReady) begin
                {e.sF, e.sD, e.sE, e.sM, e.flW} = '1;
                m_phase = 2; m_waited = 1;
            end else if (v.mdStartE) begin
                {e.sF, e.sD, e.sE, e.flM, e.go} = '1;
                m_phase = 1; m_age = 1;
            end else begin
                e.sF = lw || br; e.sD = lw || br; e.flE = lw || br;
            end
        end else if (m_phase == 1) begin
            e.busy = 1'b1;
            if (m_age == MDC) begin
                e.done = 1'b1; m_phase = 0;
            end else begin
                {e.sF, e.sD, e.sE, e.flM} = '1;
                m_age++;
            end
        end else begin
            if (v.dmemReady) begin
                m_phase = 0;
            end else begin
                {e.sF, e.sD, e.sE, e.sM, e.flW} = '1;
                if (m_waited == MTO) m_to = 1'b1;
                if (m_waited < MTO) m_waited++;
                e.to = m_to;
            end
        end
        e.to = e.to | m_to;
    endtask

    task automatic drive(input in_t v, input logic r);
        rst = r;
        rsD = v.rsD; rtD = v.rtD;
        branchD = v.branchD; jrD = v.jrD;
        rsE = v.rsE; rtE = v.rtE;
        writeRegAddrE = v.waE; writeRegAddrM = v.waM;
        writeRegAddrW = v.waW;
        Regfile_weE = v.weE; Regfile_weM = v.weM; Regfile_weW = v.weW;
        memToRegE = v.m2rE; memToRegM = v.m2rM;
        mdStartE = v.mdStartE; memReqM = v.memReqM;
        dmemReady = v.dmemReady;
    endtask

    task automatic cyc(input in_t v, input logic r);
        out_t e;
        @(posedge clk);
        #1;
        drive(v, r);
        @(negedge clk);
        model_step(v, r, e);
        chk("model", 32'(got()), 32'(e));
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(base(), 1'b1);
    endtask

    task automatic add(input string nm, input in_t v, input out_t e);
        vec_t t;
        t.name = nm; t.in = v; t.exp = e;
        tbl.push_back(t);
    endtask

    function automatic in_t rnd();
        in_t v;
        v = '0;
        v.rsD = 5'($urandom_range(0, 3));
        v.rtD = 5'($urandom_range(0, 3));
        v.rsE = 5'($urandom_range(0, 3));
        v.rtE = 5'($urandom_range(0, 3));
        v.waE = 5'($urandom_range(0, 3));
        v.waM = 5'($urandom_range(0, 3));
        v.waW = 5'($urandom_range(0, 3));
        v.branchD   = ($urandom_range(0, 3) == 0);
        v.jrD       = ($urandom_range(0, 7) == 0);
        v.weE       = 1'($urandom_range(0, 1));
        v.weM       = 1'($urandom_range(0, 1));
        v.weW       = 1'($urandom_range(0, 1));
        v.m2rE      = ($urandom_range(0, 3) == 0);
        v.m2rM      = ($urandom_range(0, 3) == 0);
        v.mdStartE  = ($urandom_range(0, 15) == 0);
        v.memReqM   = ($urandom_range(0, 3) == 0);
        v.dmemReady = ($urandom_range(0, 3) != 0);
        return v;
    endfunction

    initial begin
        in_t  v;
        out_t e;

        v = base(); e = '0;
        v.weM = 1; v.waM = 5; v.weW = 1; v.waW = 5; v.rsE = 5;
        e.fAE = 2'b10;
        add("fwdAE_M", v, e);
        v.waM = 0; e.fAE = 2'b01;
        add("fwdAE_W", v, e);
        v.waM = 5; v.rsE = 0; e.fAE = 2'b00;
        add("fwdAE_r0", v, e);
        v = base(); e = '0;
        v.weM = 1; v.waM = 7; v.rtE = 7; e.fBE = 2'b10;
        add("fwdBE_M", v, e);
        v = base(); e = '0;
        v.weW = 1; v.waW = 9; v.waM = 9; v.rtE = 9; e.fBE = 2'b01;
        add("fwdBE_W", v, e);
        v = base(); e = '0;
        v.weM = 1; v.waM = 4; v.rsD = 4; e.fAD = 1;
        add("fwdAD", v, e);
        v = base(); e = '0;
        v.weM = 1; v.waM = 6; v.rtD = 6; e.fBD = 1;
        add("fwdBD", v, e);
        v = base(); e = '0;
        v.m2rE = 1; v.waE = 8; v.rtD = 8;
        e.sF = 1; e.sD = 1; e.flE = 1;
        add("lw_use", v, e);
        v.waE = 0; v.rtD = 0; e = '0;
        add("lw_r0", v, e);
        v = base(); e = '0;
        v.branchD = 1; v.rsD = 3; v.weE = 1; v.waE = 3;
        e.sF = 1; e.sD = 1; e.flE = 1;
        add("br_E", v, e);
        v.weE = 0; e = '0;
        add("br_weE_off", v, e);
        v = base(); e = '0;
        v.branchD = 1; v.rtD = 10; v.m2rM = 1; v.weM = 1; v.waM = 10;
        e.sF = 1; e.sD = 1; e.flE = 1; e.fBD = 1;
        add("br_loadM", v, e);
        v = base(); e = '0;
        v.jrD = 1; v.rtD = 11; v.weE = 1; v.waE = 11;
        add("jr_rt", v, e);
        v.rsD = 12; v.waE = 12;
        e.sF = 1; e.sD = 1; e.flE = 1;
        add("jr_rs", v, e);

        drive(base(), 1'b0);
        v = base(); v.weM = 1; v.waM = 5; v.rsE = 5; v.mdStartE = 1;
        cyc(v, 1'b0);
        chk("rst_outs", 32'(got()), 32'd0);
        cyc(v, 1'b0);
        chk("rst_outs2", 32'(got()), 32'd0);
        idle(1);
        chk("post_rst", 32'(got()), 32'd0);

        foreach (tbl[i]) begin
            cyc(tbl[i].in, 1'b1);
            chk(tbl[i].name, 32'(got()), 32'(tbl[i].exp));
        end

        v = base(); v.branchD = 1; v.rsD = 3; v.weE = 1; v.waE = 3;
        cyc(v, 1'b1);
        chk("br_seq_stall", 32'(stallD), 32'd1);
        v.weE = 0; v.waE = 0; v.weM = 1; v.waM = 3;
        cyc(v, 1'b1);
        chk("br_seq_fwdAD", 32'(forwardAD), 32'd1);
        chk("br_seq_nostall", 32'(stallD), 32'd0);

        for (int k = 0; k <= 5; k++) begin
            v = base(); v.mdStartE = 1;
            cyc(v, 1'b1);
            chk("md_go", 32'(mdGo), 32'(k == 0 || k == 5));
            chk("md_stallE", 32'(stallE), 32'(k < 4 || k == 5));
            chk("md_flushE", 32'(flushE), 32'd0);
            chk("md_done", 32'(mdDone), 32'(k == 4));
            chk("md_busy", 32'(mdBusy), 32'(k >= 1 && k <= 4));
        end
        idle(6);

        for (int k = 0; k <= 5; k++) begin
            v = base(); v.memReqM = 1; v.dmemReady = (k == 5);
            cyc(v, 1'b1);
            chk("mem_stallM", 32'(stallM), 32'(k < 5));
            chk("mem_flushW", 32'(flushW), 32'(k < 5));
            if (k >= 2) begin
                chk("mem_timeout", 32'(memTimeout), 32'(k >= 3));
            end
        end
        idle(1);
        chk("to_sticky", 32'(memTimeout), 32'd1);

        v = base(); v.memReqM = 1; v.dmemReady = 0; v.mdStartE = 1;
        cyc(v, 1'b1);
        chk("mm_stallM", 32'(stallM), 32'd1);
        chk("mm_nogo", 32'(mdGo), 32'd0);
        v.dmemReady = 1;
        cyc(v, 1'b1);
        chk("mm_ready", 32'(stallM | mdGo), 32'd0);
        v = base(); v.mdStartE = 1;
        cyc(v, 1'b1);
        chk("mm_go", 32'(mdGo), 32'd1);
        cyc(v, 1'b1);
        chk("mm_busy", 32'(mdBusy), 32'd1);
        idle(5);

        v = base(); v.mdStartE = 1;
        cyc(v, 1'b1);
        cyc(v, 1'b1);
        cyc(v, 1'b1);
        v.weM = 1; v.waM = 5; v.rsE = 5;
        cyc(v, 1'b0);
        chk("rst_md_outs", 32'(got()), 32'd0);
        cyc(base(), 1'b1);
        chk("rst_md_idle", 32'(got()), 32'd0);
        for (int k = 0; k < 5; k++) begin
            cyc(base(), 1'b1);
            chk("rst_md_nodone", 32'(mdDone), 32'd0);
        end
        chk("rst_to_clr", 32'(memTimeout), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            cyc(rnd(), ($urandom_range(0, 99) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
